// File: rtl/display_capture.sv
// Readback monitor for a multiplexed 7-segment bus: debounces each digit dwell,
// decodes the lit pattern to a nibble and reassembles the 16-bit displayed value.
module display_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic [7:0]  digit,
    input  logic [7:0]  segment,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {SYNC, COLLECT} state_t;

    localparam logic [1:0] CODE_PAT   = 2'b01;
    localparam logic [1:0] CODE_STRB  = 2'b10;
    localparam logic [1:0] CODE_ORDER = 2'b11;

    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'h01: decode_seg = 5'h10;
            7'h4F: decode_seg = 5'h11;
            7'h12: decode_seg = 5'h12;
            7'h06: decode_seg = 5'h13;
            7'h4C: decode_seg = 5'h14;
            7'h24: decode_seg = 5'h15;
            7'h20: decode_seg = 5'h16;
            7'h0F: decode_seg = 5'h17;
            7'h00: decode_seg = 5'h18;
            7'h04: decode_seg = 5'h19;
            7'h08: decode_seg = 5'h1A;
            7'h60: decode_seg = 5'h1B;
            7'h31: decode_seg = 5'h1C;
            7'h42: decode_seg = 5'h1D;
            7'h30: decode_seg = 5'h1E;
            7'h38: decode_seg = 5'h1F;
            default: decode_seg = 5'h00;
        endcase
    endfunction

    logic [7:0]    dig_q, seg_q;
    logic [CW-1:0] settle_cnt, settle_nxt;
    logic          changed, capture;
    logic [7:0]    smp_dig;
    logic [6:0]    smp_pat;
    logic [4:0]    dec;
    logic          pat_ok, strobe_ok, blank;
    logic [1:0]    idx;

    assign changed = ({digit, segment} != {dig_q, seg_q});

    // The settle count restarts on the edge that loads a new sample, so the
    // capture lands SETTLE-1 edges after the first edge that saw the value.
    always_comb begin
        if (changed)
            settle_nxt = CW'(1);
        else if (settle_cnt == CW'(SETTLE))
            settle_nxt = settle_cnt;
        else
            settle_nxt = settle_cnt + CW'(1);
    end

    always_comb begin
        if (SETTLE == 1) begin
            smp_dig = digit;
            smp_pat = segment[7:1];
        end else begin
            smp_dig = dig_q;
            smp_pat = seg_q[7:1];
        end
    end

    assign dec    = decode_seg(smp_pat);
    assign pat_ok = dec[4];
    assign blank  = (smp_dig == 8'hFF);

    always_comb begin
        strobe_ok = (smp_dig[7:4] == 4'hF);
        idx       = 2'd0;
        unique case (smp_dig[3:0])
            4'hE:    idx = 2'd0;
            4'hD:    idx = 2'd1;
            4'hB:    idx = 2'd2;
            4'h7:    idx = 2'd3;
            default: strobe_ok = 1'b0;
        endcase
    end

    assign capture = (settle_nxt == CW'(SETTLE)) &&
                     (changed || settle_cnt != CW'(SETTLE)) && !blank;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            dig_q      <= 8'hFF;
            seg_q      <= 8'hFF;
            settle_cnt <= '0;
        end else begin
            dig_q      <= digit;
            seg_q      <= segment;
            settle_cnt <= settle_nxt;
        end
    end

    state_t     state, state_nxt;
    logic [1:0] expect_q, expect_nxt;
    logic       store_nib, frame_done, err_set;
    logic [1:0] code_nxt;

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) state <= SYNC;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch can be inferred.
    always_comb begin
        state_nxt  = state;
        expect_nxt = expect_q;
        store_nib  = 1'b0;
        frame_done = 1'b0;
        err_set    = 1'b0;
        code_nxt   = err_code;
        if (capture) begin
            unique case (state)
                SYNC: begin
                    if (!strobe_ok) begin
                        err_set  = 1'b1;
                        code_nxt = CODE_STRB;
                    end else if (idx == 2'd0 && pat_ok) begin
                        store_nib  = 1'b1;
                        expect_nxt = 2'd1;
                        state_nxt  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!pat_ok) begin
                        err_set   = 1'b1;
                        code_nxt  = CODE_PAT;
                        state_nxt = SYNC;
                    end else if (!strobe_ok) begin
                        err_set   = 1'b1;
                        code_nxt  = CODE_STRB;
                        state_nxt = SYNC;
                    end else if (idx != expect_q) begin
                        err_set  = 1'b1;
                        code_nxt = CODE_ORDER;
                        // A stray digit 0 is the start of the next frame.
                        if (idx == 2'd0) begin
                            store_nib  = 1'b1;
                            expect_nxt = 2'd1;
                        end else begin
                            state_nxt = SYNC;
                        end
                    end else if (idx == 2'd3) begin
                        frame_done = 1'b1;
                        state_nxt  = SYNC;
                    end else begin
                        store_nib  = 1'b1;
                        expect_nxt = expect_q + 2'd1;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    logic [3:0] nib0, nib1, nib2;

    // NOTE: the partial-frame nibbles are reset along with everything else so
    // a reset mid-frame cannot leak old digits into the next value.
    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            expect_q <= 2'd0;
            nib0     <= 4'h0;
            nib1     <= 4'h0;
            nib2     <= 4'h0;
            value    <= 16'h0000;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            expect_q <= expect_nxt;
            valid    <= frame_done;
            err      <= err_set;
            err_code <= code_nxt;
            if (store_nib) begin
                case (idx)
                    2'd0:    nib0 <= dec[3:0];
                    2'd1:    nib1 <= dec[3:0];
                    default: nib2 <= dec[3:0];
                endcase
            end
            if (frame_done)
                value <= {dec[3:0], nib2, nib1, nib0};
        end
    end

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else if (capture)
            tcnt <= '0;
        else if (tcnt < TW'(TIMEOUT))
            tcnt <= tcnt + TW'(1);
    end

    assign stale = (tcnt >= TW'(TIMEOUT));

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: directed frames push expected valid/err
// events into a queue, a monitor pops and compares them as the DUT emits them.
module tb_display_capture;

    logic        clk5 = 1'b0;
    logic        reset;
    logic [7:0]  digit;
    logic [7:0]  segment;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [1:0]  err_code;
    logic        stale;

    display_capture #(.SETTLE(4), .TIMEOUT(4096)) dut (
        .clk5     (clk5),
        .reset    (reset),
        .digit    (digit),
        .segment  (segment),
        .value    (value),
        .valid    (valid),
        .err      (err),
        .err_code (err_code),
        .stale    (stale)
    );

    always #5 clk5 = ~clk5;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_valid(input logic [15:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = v;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = {14'd0, c};
        sb.push_back(e);
    endtask

    task automatic hold(input logic [7:0] d, input logic [6:0] p, input int n);
        digit   = d;
        segment = {p, 1'b1};
        repeat (n) @(posedge clk5);
        #1;
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        hold(8'hFE, p0, 20);
        hold(8'hFD, p1, 20);
        hold(8'hFB, p2, 20);
        hold(8'hF7, p3, 20);
        hold(8'hFF, 7'h7F, 10);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk5);
            k++;
        end
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk5);
            if (valid || err) begin
                if (sb.size() == 0) begin
                    check(valid ? "unexpected_valid" : "unexpected_err", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (valid) begin
                        check("event_is_valid", 0, e.is_err);
                        check("valid_value", value, e.data);
                    end else begin
                        check("event_is_err", 1, e.is_err);
                        check("err_code", err_code, e.data);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b0;
        digit   = 8'hFF;
        segment = 8'hFF;
        repeat (3) @(posedge clk5);
        #1;
        check("rst_value", value, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_stale", stale, 0);
        reset = 1'b1;
        hold(8'hFF, 7'h7F, 5);

        // T1: 3, C, 5, A on digits 0..3
        push_valid(16'hA5C3);
        frame(7'h06, 7'h31, 7'h24, 7'h08);
        drain("t1_drain");
        check("t1_value", value, 16'hA5C3);

        // T2: digit 2 skipped -> out of order on digit 3
        push_err(2'b11);
        hold(8'hFE, 7'h06, 20);
        hold(8'hFD, 7'h31, 20);
        hold(8'hF7, 7'h08, 20);
        hold(8'hFF, 7'h7F, 10);
        drain("t2_drain");
        check("t2_value_held", value, 16'hA5C3);
        push_valid(16'h4321);
        frame(7'h4F, 7'h12, 7'h06, 7'h4C);
        drain("t2_recover");

        // T3: undecodable pattern on digit 1
        push_err(2'b01);
        frame(7'h06, 7'h7E, 7'h24, 7'h08);
        drain("t3_drain");
        check("t3_value_held", value, 16'h4321);

        // T4: 3-cycle glitch on digit 1 before the real pattern settles
        push_valid(16'hA5C3);
        hold(8'hFE, 7'h06, 20);
        hold(8'hFD, 7'h4F, 3);
        hold(8'hFD, 7'h31, 17);
        hold(8'hFB, 7'h24, 20);
        hold(8'hF7, 7'h08, 20);
        hold(8'hFF, 7'h7F, 10);
        drain("t4_drain");

        // T5: two strobes low, then blank long enough to go stale
        push_err(2'b10);
        hold(8'hFC, 7'h06, 10);
        drain("t5_drain");
        check("t5_code_held", err_code, 2'b10);
        hold(8'hFF, 7'h7F, 4000);
        check("t5_not_stale", stale, 0);
        hold(8'hFF, 7'h7F, 100);
        check("t5_stale", stale, 1);
        hold(8'hFE, 7'h06, 20);
        check("t5_stale_cleared", stale, 0);

        // T6: reset after digits 0 and 1 of a frame
        hold(8'hFD, 7'h31, 20);
        #2;
        reset = 1'b0;
        #1;
        check("t6_value", value, 0);
        check("t6_valid", valid, 0);
        check("t6_err", err, 0);
        check("t6_err_code", err_code, 0);
        check("t6_stale", stale, 0);
        digit   = 8'hFF;
        segment = 8'hFF;
        repeat (3) @(posedge clk5);
        #1;
        reset = 1'b1;
        hold(8'hFF, 7'h7F, 5);
        push_valid(16'hA5C3);
        frame(7'h06, 7'h31, 7'h24, 7'h08);
        drain("t6_drain");
        check("t6_value_after", value, 16'hA5C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
